sram_port_arbiter: RTL and testbench

- Shares the single-port operand/result SRAM between two requesters: port 0 (host loader) and port 1 (calculator controller).
- Uses a req/gnt handshake with round-robin fairness.
- Supports an optional burst lock, so the controller can stream read_start..read_end or write beats without interleaving.
- Sits between the requesters and the SRAM macro. It returns read data to whichever requester issued the read.

---
 rtl/sram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter for the single-port operand/result SRAM, with optional burst lock.
// Grant and SRAM drive are combinational in the request cycle; read data returns one cycle later.
// A non-granted port simply holds req_i; an owner under lock is preempted after LOCK_MAX beats.
// Optional statistics outputs are enabled with `define ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_i,
  input  logic [1:0]            lock_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           gnt_cnt0_o,
  output logic [15:0]           gnt_cnt1_o,
  output logic [7:0]            force_cnt_o
`endif
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic {S_ARB = 1'b0, S_OWN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rtag_vld_q, rtag_vld_d;
  logic             rtag_port_q, rtag_port_d;

  logic [1:0]       gnt;
  logic             gnt_any;
  logic             gnt_port;
  logic             owner_req;
  logic             owner_lock;
  logic             other_req;
  logic [CNT_W-1:0] cnt_nx;
  logic             force_exit;

  // State register: FSM state, owner, round-robin pointer, lock counter and read tag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_ARB;
      owner_q     <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      rtag_vld_q  <= 1'b0;
      rtag_port_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rtag_vld_q  <= rtag_vld_d;
      rtag_port_q <= rtag_port_d;
    end
  end

  assign owner_req  = owner_q ? req_i[1]  : req_i[0];
  assign owner_lock = owner_q ? lock_i[1] : lock_i[0];
  assign other_req  = owner_q ? req_i[0]  : req_i[1];
  // Lock counter saturates so a long uncontended burst still preempts at once when the other port arrives
  assign cnt_nx     = (owner_req && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign force_exit = (state_q == S_OWN) && owner_req && owner_lock &&
                      (cnt_nx == CNT_MAX) && other_req;

  // Next-state: round-robin in ARB, ownership tracking and exit conditions in OWN
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rtag_vld_d  = gnt_any && !mem_we_o;
    rtag_port_d = gnt_port;
    if (state_q == S_ARB) begin
      if (gnt_any) begin
        ptr_d = ~gnt_port;
        if (lock_i[gnt_port]) begin
          state_d = S_OWN;
          owner_d = gnt_port;
          cnt_d   = CNT_W'(1);
        end
      end
    end else begin
      cnt_d = cnt_nx;
      if (!owner_req || !owner_lock || force_exit) begin
        state_d = S_ARB;
        cnt_d   = '0;
      end
      if (force_exit) begin
        ptr_d = ~owner_q;
      end
    end
  end

  // Output: one-hot grant and SRAM drive from the granted port; all quiet while in reset
  always_comb begin
    gnt = 2'b00;
    if (rst_ni) begin
      if (state_q == S_OWN) begin
        gnt[owner_q] = owner_req;
      end else begin
        case (req_i)
          2'b01:   gnt = 2'b01;
          2'b10:   gnt = 2'b10;
          2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
          default: gnt = 2'b00;
        endcase
      end
    end
    gnt_any     = |gnt;
    gnt_port    = gnt[1];
    mem_en_o    = gnt_any;
    mem_we_o    = gnt_any && (gnt_port ? we_i[1] : we_i[0]);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_any) begin
      mem_addr_o  = gnt_port ? addr_i[2*ADDR_W-1:ADDR_W]  : addr_i[ADDR_W-1:0];
      mem_wdata_o = gnt_port ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = {rtag_vld_q & rtag_port_q, rtag_vld_q & ~rtag_port_q};
  assign rdata_o  = rtag_vld_q ? mem_rdata_i : '0;

`ifdef ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt1_q;
  logic [7:0]  force_cnt_q;

  // Saturating grant and forced-rotation counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_cnt0_q  <= '0;
      gnt_cnt1_q  <= '0;
      force_cnt_q <= '0;
    end else begin
      if (gnt[0] && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (gnt[1] && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
      if (force_exit && (force_cnt_q != 8'hFF)) force_cnt_q <= force_cnt_q + 8'd1;
    end
  end

  assign gnt_cnt0_o  = gnt_cnt0_q;
  assign gnt_cnt1_o  = gnt_cnt1_q;
  assign force_cnt_o = force_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: two instances (LOCK_MAX 16 and 4) share stimulus,
// each backed by its own behavioural SRAM with one-cycle read latency.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [1:0]   lock = 2'b00;
  logic [1:0]   we = 2'b00;
  logic [19:0]  addr = '0;
  logic [127:0] wdata = '0;

  logic [1:0]   gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [63:0]  rdata_a, rdata_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic         mem_en_a, mem_we_a, mem_en_b, mem_we_b;
  logic [9:0]   mem_addr_a, mem_addr_b;
`ifdef ARB_STATS_EN
  logic [15:0]  gc0_a, gc1_a, gc0_b, gc1_b;
  logic [7:0]   fc_a, fc_b;
`endif

  logic [63:0]  mem_a [1024];
  logic [63:0]  mem_b [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(10), .DATA_W(64), .LOCK_MAX(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .mem_en_o(mem_en_a), .mem_we_o(mem_we_a),
    .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a)
`ifdef ARB_STATS_EN
    , .gnt_cnt0_o(gc0_a), .gnt_cnt1_o(gc1_a), .force_cnt_o(fc_a)
`endif
  );

  sram_port_arbiter #(.ADDR_W(10), .DATA_W(64), .LOCK_MAX(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .mem_en_o(mem_en_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b)
`ifdef ARB_STATS_EN
    , .gnt_cnt0_o(gc0_b), .gnt_cnt1_o(gc1_b), .force_cnt_o(fc_b)
`endif
  );

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      else          mem_rdata_a <= mem_a[mem_addr_a];
    end
    if (mem_en_b) begin
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      else          mem_rdata_b <= mem_b[mem_addr_b];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00; lock = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b11; lock = 2'b11; we = 2'b11; addr = 20'hABCDE; wdata = {2{64'hFFFF}};
    #2;
    checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt_a); end
    checks++; if (rvalid_a !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", rvalid_a); end
    checks++; if (mem_en_a !== 1'b0 || mem_we_a !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we got %b%b want 00", mem_en_a, mem_we_a); end
    checks++; if (mem_addr_a !== 10'h0 || mem_wdata_a !== 64'h0) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr_a, mem_wdata_a); end
    checks++; if (rdata_a !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_a); end
    do_reset();
  endtask

  // Port 0 writes the data used by the read tests; also checks the write path and that writes make no rvalid
  task automatic test_write_beats();
    logic [9:0]  ea;
    logic [63:0] ed;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ea = (i == 0) ? 10'h005 : 10'(10'h010 + i - 1);
      ed = (i == 0) ? 64'hDEAD : 64'(64'h100 + i - 1);
      req = 2'b01; we = 2'b01; addr[9:0] = ea; wdata[63:0] = ed;
      @(negedge clk);
      checks++; if (gnt_a !== 2'b01 || mem_we_a !== 1'b1) begin errors++; $display("FAIL wr_gnt[%0d] got %b/%b want 01/1", i, gnt_a, mem_we_a); end
      checks++; if (mem_addr_a !== ea || mem_wdata_a !== ed) begin errors++; $display("FAIL wr_bus[%0d] got %h/%h want %h/%h", i, mem_addr_a, mem_wdata_a, ea, ed); end
      checks++; if (rvalid_a !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid[%0d] got %b want 00", i, rvalid_a); end
      cyc();
    end
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b00 || mem_en_a !== 1'b0 || mem_addr_a !== 10'h0) begin errors++; $display("FAIL wr_idle got rv=%b en=%b addr=%h want 00/0/0", rvalid_a, mem_en_a, mem_addr_a); end
    cyc();
  endtask

  task automatic test_single_read();
    do_reset();
    req = 2'b01; we = 2'b00; addr[9:0] = 10'h005;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b01 || mem_en_a !== 1'b1 || mem_we_a !== 1'b0) begin errors++; $display("FAIL single_gnt got %b en=%b we=%b want 01/1/0", gnt_a, mem_en_a, mem_we_a); end
    checks++; if (mem_addr_a !== 10'h005) begin errors++; $display("FAIL single_addr got %h want 005", mem_addr_a); end
    cyc();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b01 || rdata_a !== 64'hDEAD) begin errors++; $display("FAIL single_rdata got %b/%h want 01/dead", rvalid_a, rdata_a); end
    checks++; if (gnt_a !== 2'b00 || mem_en_a !== 1'b0) begin errors++; $display("FAIL single_idle got %b/%b want 00/0", gnt_a, mem_en_a); end
    cyc();
  endtask

  task automatic test_contention();
    logic [1:0]  eg, pg;
    logic [9:0]  ea;
    logic [63:0] pd;
    do_reset();
    req = 2'b11; lock = 2'b00; we = 2'b00; addr = {10'h010, 10'h005};
    pg = 2'b00; pd = '0;
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ea = (i % 2 == 0) ? 10'h005 : 10'h010;
      @(negedge clk);
      checks++; if (gnt_a !== eg || mem_addr_a !== ea) begin errors++; $display("FAIL rr_gnt[%0d] got %b/%h want %b/%h", i, gnt_a, mem_addr_a, eg, ea); end
      if (i > 0) begin
        checks++; if (rvalid_a !== pg || rdata_a !== pd) begin errors++; $display("FAIL rr_rvalid[%0d] got %b/%h want %b/%h", i, rvalid_a, rdata_a, pg, pd); end
      end
      pg = eg;
      pd = (i % 2 == 0) ? 64'hDEAD : 64'h100;
      cyc();
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b10 || rdata_a !== 64'h100) begin errors++; $display("FAIL rr_last got %b/%h want 10/100", rvalid_a, rdata_a); end
    cyc();
  endtask

  task automatic test_burst_lock();
    logic [1:0]  erv;
    logic [63:0] erd;
    do_reset();
    req = 2'b01; lock = 2'b00; we = 2'b00; addr[9:0] = 10'h005;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req = 2'b11;
      lock = (i == 4) ? 2'b00 : 2'b10;
      addr[19:10] = 10'(10'h010 + i);
      erv = (i == 0) ? 2'b01 : 2'b10;
      erd = (i == 0) ? 64'hDEAD : 64'(64'h100 + i - 1);
      @(negedge clk);
      checks++; if (gnt_a !== 2'b10 || mem_addr_a !== 10'(10'h010 + i)) begin errors++; $display("FAIL lock_gnt[%0d] got %b/%h want 10/%h", i, gnt_a, mem_addr_a, 10'(10'h010 + i)); end
      checks++; if (rvalid_a !== erv || rdata_a !== erd) begin errors++; $display("FAIL lock_rvalid[%0d] got %b/%h want %b/%h", i, rvalid_a, rdata_a, erv, erd); end
      cyc();
    end
    req = 2'b01; lock = 2'b00;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b01 || mem_addr_a !== 10'h005) begin errors++; $display("FAIL lock_after got %b/%h want 01/005", gnt_a, mem_addr_a); end
    checks++; if (rvalid_a !== 2'b10 || rdata_a !== 64'h104) begin errors++; $display("FAIL lock_last_rd got %b/%h want 10/104", rvalid_a, rdata_a); end
    cyc();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b01 || rdata_a !== 64'hDEAD) begin errors++; $display("FAIL lock_p0_rd got %b/%h want 01/dead", rvalid_a, rdata_a); end
    cyc();
  endtask

  task automatic test_forced_rotation();
    logic [9:0] pat;
    logic [1:0] eg;
    pat = 10'b0111101111;
    do_reset();
    req = 2'b01; lock = 2'b00; we = 2'b00; addr = {10'h010, 10'h005};
    cyc();
    for (int i = 0; i < 10; i++) begin
      req = 2'b11; lock = 2'b10;
      eg = pat[i] ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++; if (gnt_b !== eg) begin errors++; $display("FAIL force_gnt[%0d] got %b want %b", i, gnt_b, eg); end
      checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL nolimit_gnt[%0d] got %b want 10", i, gnt_a); end
      cyc();
    end
    req = 2'b00; lock = 2'b00;
    cyc();
  endtask

  task automatic test_write_read();
    do_reset();
    req = 2'b01; we = 2'b01; addr[9:0] = 10'h020; wdata[63:0] = 64'h1234;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b01 || mem_we_a !== 1'b1 || mem_wdata_a !== 64'h1234) begin errors++; $display("FAIL wr_rd_write got %b/%b/%h want 01/1/1234", gnt_a, mem_we_a, mem_wdata_a); end
    cyc();
    req = 2'b10; we = 2'b00; addr[19:10] = 10'h020;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b10 || mem_we_a !== 1'b0 || mem_addr_a !== 10'h020) begin errors++; $display("FAIL wr_rd_read got %b/%b/%h want 10/0/020", gnt_a, mem_we_a, mem_addr_a); end
    checks++; if (rvalid_a !== 2'b00) begin errors++; $display("FAIL wr_rd_no_rvalid got %b want 00", rvalid_a); end
    cyc();
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b10 || rdata_a !== 64'h1234) begin errors++; $display("FAIL wr_rd_data got %b/%h want 10/1234", rvalid_a, rdata_a); end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 2'b01; lock = 2'b00; we = 2'b00; addr = {10'h011, 10'h005};
    cyc();
    req = 2'b11; lock = 2'b10;
    cyc();
    #1;
    checks++; if (gnt_a !== 2'b10 || rvalid_a !== 2'b10) begin errors++; $display("FAIL arst_pre got %b/%b want 10/10", gnt_a, rvalid_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (gnt_a !== 2'b00 || rvalid_a !== 2'b00 || mem_en_a !== 1'b0) begin errors++; $display("FAIL arst_drop got %b/%b/%b want 00/00/0", gnt_a, rvalid_a, mem_en_a); end
    checks++; if (rdata_a !== 64'h0) begin errors++; $display("FAIL arst_rdata got %h want 0", rdata_a); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b01 || rvalid_a !== 2'b00) begin errors++; $display("FAIL arst_after got %b/%b want 01/00", gnt_a, rvalid_a); end
    cyc();
    @(negedge clk);
    checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL arst_next got %b want 10", gnt_a); end
    cyc();
    req = 2'b00; lock = 2'b00;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_beats();
    test_single_read();
    test_contention();
    test_burst_lock();
    test_forced_rotation();
    test_write_read();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
